// File: rtl/dmux4_stream.sv
// dmux4_stream: registered 1-to-4 word demultiplexer with a small FIFO per output channel.
// Each accepted word is written to the FIFO selected by sel. Consumers pop their
// channel independently, so a full channel only stalls words that target it.
// Optional feature: define DMUX4_STREAM_COUNT_EN to add the per-channel accepted-word
// counters count_a..count_d and the clear_counts input.
module dmux4_stream #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH_LOG2 = 1
) (
   input  logic             clk,
   input  logic             reset,
`ifdef DMUX4_STREAM_COUNT_EN
   input  logic             clear_counts,
   output logic [15:0]      count_a,
   output logic [15:0]      count_b,
   output logic [15:0]      count_c,
   output logic [15:0]      count_d,
`endif
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             valid_a,
   output logic             valid_b,
   output logic             valid_c,
   output logic             valid_d,
   input  logic             ready_a,
   input  logic             ready_b,
   input  logic             ready_c,
   input  logic             ready_d
);

   localparam int unsigned NumCh = 4;
   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned CntW  = DEPTH_LOG2 + 1;

   typedef logic [WIDTH-1:0]      word_t;
   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [CntW-1:0]       cnt_t;

   localparam cnt_t Full = cnt_t'(Depth);

   // Per-channel FIFO storage and bookkeeping
   word_t mem_q    [NumCh][Depth];
   ptr_t  wr_ptr_q [NumCh];
   ptr_t  wr_ptr_d [NumCh];
   ptr_t  rd_ptr_q [NumCh];
   ptr_t  rd_ptr_d [NumCh];
   cnt_t  cnt_q    [NumCh];
   cnt_t  cnt_d    [NumCh];

   logic [NumCh-1:0] ready_vec;
   logic [NumCh-1:0] valid_vec;
   logic [NumCh-1:0] pop_vec;
   logic [NumCh-1:0] push_vec;

   assign ready_vec = {ready_d, ready_c, ready_b, ready_a};

   // Channel status: non-empty flag and consumer pop
   always_comb begin
      valid_vec = '0;
      pop_vec   = '0;
      for (int i = 0; i < NumCh; i++) begin
         valid_vec[i] = (cnt_q[i] != '0);
         pop_vec[i]   = valid_vec[i] & ready_vec[i];
      end
   end

   // Input handshake: a full channel that pops this cycle can still take a word.
   // in_valid is deliberately kept out of in_ready.
   always_comb begin
      in_ready = ~reset & ((cnt_q[sel] < Full) | pop_vec[sel]);
      push_vec = '0;
      if (in_valid && in_ready) begin
         push_vec[sel] = 1'b1;
      end
   end

   // FIFO next-state: pointers advance independently, occupancy nets push against pop
   always_comb begin
      for (int i = 0; i < NumCh; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         cnt_d[i]    = cnt_q[i];
         if (push_vec[i]) begin
            wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(1);
         end
         if (pop_vec[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(1);
         end
         unique case ({push_vec[i], pop_vec[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + cnt_t'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - cnt_t'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // FIFO state registers; storage is cleared too so outputs read 0 after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NumCh; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            for (int j = 0; j < Depth; j++) begin
               mem_q[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < NumCh; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
            if (push_vec[i]) begin
               mem_q[i][wr_ptr_q[i]] <= in;
            end
         end
      end
   end

   assign out_a   = mem_q[0][rd_ptr_q[0]];
   assign out_b   = mem_q[1][rd_ptr_q[1]];
   assign out_c   = mem_q[2][rd_ptr_q[2]];
   assign out_d   = mem_q[3][rd_ptr_q[3]];
   assign valid_a = valid_vec[0];
   assign valid_b = valid_vec[1];
   assign valid_c = valid_vec[2];
   assign valid_d = valid_vec[3];

`ifdef DMUX4_STREAM_COUNT_EN
   logic [15:0] acc_q [NumCh];
   logic [15:0] acc_d [NumCh];

   // Accepted-word counters; clear wins over a same-cycle increment, wrap is natural
   always_comb begin
      for (int i = 0; i < NumCh; i++) begin
         acc_d[i] = acc_q[i];
         if (clear_counts) begin
            acc_d[i] = '0;
         end else if (push_vec[i]) begin
            acc_d[i] = acc_q[i] + 16'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NumCh; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumCh; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign count_a = acc_q[0];
   assign count_b = acc_q[1];
   assign count_c = acc_q[2];
   assign count_d = acc_q[3];
`endif

endmodule

// File: tb/tb_dmux4_stream.sv
// Directed self-checking bench for dmux4_stream.
// Counter checks are compiled in when DMUX4_STREAM_COUNT_EN is defined.
module tb_dmux4_stream;

   logic        clk;
   logic        reset;
   logic [15:0] din;
   logic [1:0]  sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_a, out_b, out_c, out_d;
   logic        valid_a, valid_b, valid_c, valid_d;
   logic        ready_a, ready_b, ready_c, ready_d;
`ifdef DMUX4_STREAM_COUNT_EN
   logic        clear_counts;
   logic [15:0] count_a, count_b, count_c, count_d;
`endif

   int unsigned n_checks;
   int unsigned n_bad;

   logic [3:0]  valid_v;
   logic [15:0] out_v [4];
   logic [15:0] vals  [4];

   assign valid_v  = {valid_d, valid_c, valid_b, valid_a};
   assign out_v[0] = out_a;
   assign out_v[1] = out_b;
   assign out_v[2] = out_c;
   assign out_v[3] = out_d;

   dmux4_stream #(
      .WIDTH      (16),
      .DEPTH_LOG2 (1)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
`ifdef DMUX4_STREAM_COUNT_EN
      .clear_counts (clear_counts),
      .count_a      (count_a),
      .count_b      (count_b),
      .count_c      (count_c),
      .count_d      (count_d),
`endif
      .in           (din),
      .sel          (sel),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_a        (out_a),
      .out_b        (out_b),
      .out_c        (out_c),
      .out_d        (out_d),
      .valid_a      (valid_a),
      .valid_b      (valid_b),
      .valid_c      (valid_c),
      .valid_d      (valid_d),
      .ready_a      (ready_a),
      .ready_b      (ready_b),
      .ready_c      (ready_c),
      .ready_d      (ready_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_bad    = 0;
      vals[0]  = 16'h1111;
      vals[1]  = 16'h2222;
      vals[2]  = 16'h3333;
      vals[3]  = 16'h4444;
      reset    = 1'b1;
      din      = '0;
      sel      = '0;
      in_valid = 1'b0;
      {ready_d, ready_c, ready_b, ready_a} = 4'b0000;
`ifdef DMUX4_STREAM_COUNT_EN
      clear_counts = 1'b0;
`endif

      // Reset state
      #1;
      check("rst_valid", 32'(valid_v), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 4; i++) check($sformatf("rst_out%0d", i), 32'(out_v[i]), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'h1);

      // One push per channel, consumers stalled
      for (int k = 0; k < 4; k++) begin
         sel      = 2'(k);
         din      = vals[k];
         in_valid = 1'b1;
         #1;
         check($sformatf("t1_in_ready%0d", k), 32'(in_ready), 32'h1);
         tick();
         check($sformatf("t1_valid%0d", k), 32'(valid_v[k]), 32'h1);
         check($sformatf("t1_out%0d", k), 32'(out_v[k]), 32'(vals[k]));
      end
      in_valid = 1'b0;

      // Drain all four channels in one cycle
      {ready_d, ready_c, ready_b, ready_a} = 4'b1111;
      tick();
      check("drain_valid", 32'(valid_v), 32'h0);
      {ready_d, ready_c, ready_b, ready_a} = 4'b0000;

      // Fill channel b, then a third word to b must stall
      sel = 2'd1; din = 16'hAAAA; in_valid = 1'b1;
      tick();
      din = 16'hBBBB;
      tick();
      din = 16'hCCCC;
      #1;
      check("b_full_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("b_held_out", 32'(out_b), 32'hAAAA);
      check("b_held_valid", 32'(valid_b), 32'h1);
      // Other channel is unaffected by b being full
      sel = 2'd2; din = 16'hDDDD;
      #1;
      check("c_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("c_valid", 32'(valid_c), 32'h1);
      check("c_out", 32'(out_c), 32'hDDDD);

      // Full channel b popping while pushing
      sel = 2'd1; din = 16'hCCCC; ready_b = 1'b1;
      #1;
      check("b_full_pop_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("b_seq1", 32'(out_b), 32'hBBBB);
      in_valid = 1'b0; ready_b = 1'b0;
      #1;
      check("b_still_full", 32'(in_ready), 32'h0);
      ready_b = 1'b1;
      tick();
      check("b_seq2", 32'(out_b), 32'hCCCC);
      check("b_seq2_valid", 32'(valid_b), 32'h1);
      tick();
      check("b_empty", 32'(valid_b), 32'h0);
      ready_b = 1'b0;

      // Back-to-back stream on channel a with consumer always ready
      ready_a = 1'b1; sel = 2'd0; in_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         din = 16'(k);
         #1;
         check($sformatf("a_stream_ready%0d", k), 32'(in_ready), 32'h1);
         tick();
         check($sformatf("a_stream_valid%0d", k), 32'(valid_a), 32'h1);
         check($sformatf("a_stream_out%0d", k), 32'(out_a), 32'(k));
      end
      in_valid = 1'b0;
      tick();
      check("a_stream_end", 32'(valid_a), 32'h0);
      ready_a = 1'b0;

      // Load a and d, then assert reset between edges
      sel = 2'd0; din = 16'h5A5A; in_valid = 1'b1;
      tick();
      sel = 2'd3; din = 16'hA5A5;
      tick();
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(valid_v), 32'b1101);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(valid_v), 32'h0);
      check("mid_rst_in_ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 4; i++) check($sformatf("mid_rst_out%0d", i), 32'(out_v[i]), 32'h0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("rel_valid", 32'(valid_v), 32'h0);

`ifdef DMUX4_STREAM_COUNT_EN
      // Accepted-word counter on channel d
      check("cnt_rst", 32'(count_d), 32'h0);
      ready_d = 1'b1; sel = 2'd3; in_valid = 1'b1; din = 16'h0D0D;
      for (int k = 0; k < 3; k++) tick();
      check("cnt_three", 32'(count_d), 32'h3);
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
      check("cnt_clear_prio", 32'(count_d), 32'h0);
      for (int k = 0; k < 65535; k++) begin
         @(posedge clk);
      end
      #1;
      check("cnt_max", 32'(count_d), 32'hFFFF);
      tick();
      check("cnt_wrap", 32'(count_d), 32'h0);
      in_valid = 1'b0;
      ready_d  = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
